// File: rtl/seq_detect_scheduler_pkg.sv
// Shared types and the 1101 detector step function used by the fsm_* family of blocks.
package seq_detect_scheduler_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_t;

  localparam logic [3:0] PATTERN = 4'b1101;

  typedef struct packed {
    det_state_t nxt;
    logic       hit;
  } det_step_t;

  // One bit of progress for a prefix-tracking 1101 matcher; hit is the Mealy detect.
  function automatic det_step_t det_step(det_state_t cur, logic b, logic overlap);
    det_step_t r;
    r.nxt = S0;
    r.hit = 1'b0;
    case (cur)
      S0: r.nxt = (b == PATTERN[3]) ? S1 : S0;
      S1: r.nxt = (b == PATTERN[2]) ? S2 : S0;
      S2: r.nxt = (b == PATTERN[1]) ? S3 : S2;
      S3: begin
        if (b == PATTERN[0]) begin
          r.hit = 1'b1;
          r.nxt = overlap ? S1 : S0;
        end else begin
          r.nxt = S0;
        end
      end
      default: r.nxt = S0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Requester/logger-facing bundle of the shared sequence detector.
interface seq_detect_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 8
);
  logic              overlap;
  logic              clr;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] bits;
  logic [NUM_CH-1:0] gnt;
  logic              det_valid;
  logic [CH_W-1:0]   det_ch;
  logic [CNT_W-1:0]  hit_cnt;

  modport master (
    output overlap, clr, req, bits,
    input  gnt, det_valid, det_ch, hit_cnt
  );

  modport slave (
    input  overlap, clr, req, bits,
    output gnt, det_valid, det_ch, hit_cnt
  );
endinterface

// File: rtl/seq_detect_scheduler_arbiter.sv
// Round-robin arbiter: search starts one past the last granted channel.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            take,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] ptr;

  always_comb begin : search
    int   idx;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = ID_W'(idx);
      end
    end
  end

  // Reset pointer to the last channel so channel 0 wins the first search.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= ID_W'(N - 1);
    end else if (take && |gnt) begin
      ptr <= gnt_id;
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// One 1101 detector datapath time-shared across NUM_CH serial requesters with per-channel context.
module seq_detect_scheduler
  import seq_detect_scheduler_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  seq_detect_scheduler_if.slave bus
);

  logic [NUM_CH-1:0] req_eff;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_id;
  logic              take;
  det_state_t        st [NUM_CH];
  det_step_t         step;
  logic              det_valid_q;
  logic [CH_W-1:0]   det_ch_q;
  logic [CNT_W-1:0]  hit_cnt_q;

  // Masking requests during reset or flush keeps bits unconsumed and the pointer frozen.
  assign req_eff = (rst_n && !bus.clr) ? bus.req : '0;
  assign take    = |gnt;

  rr_arbiter #(
    .N    (NUM_CH),
    .ID_W (CH_W)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_eff),
    .take   (take),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    step = det_step(st[gnt_id], bus.bits[gnt_id], bus.overlap);
  end

  // Flush beats a same-cycle detection: neither pulse nor count is produced.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st[i] <= S0;
      end
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      hit_cnt_q   <= '0;
    end else begin
      det_valid_q <= take && step.hit;
      if (take) begin
        st[gnt_id] <= step.nxt;
      end
      if (take && step.hit) begin
        det_ch_q <= gnt_id;
        if (hit_cnt_q != '1) begin
          hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.gnt       = gnt;
  assign bus.det_valid = det_valid_q;
  assign bus.det_ch    = det_ch_q;
  assign bus.hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench for seq_detect_scheduler: a reference arbiter/matcher model predicts grants and pulses.
module tb_seq_detect_scheduler;
  import seq_detect_scheduler_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 8;

  typedef struct {
    logic             valid;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  seq_detect_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  seq_detect_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb [$];
  exp_t exp_e;
  logic have_exp;
  logic [NUM_CH-1:0] exp_gnt;
  logic [NUM_CH-1:0] obs_gnt;
  logic              obs_dv;
  logic [CH_W-1:0]   obs_ch;
  logic [CNT_W-1:0]  obs_cnt;
  int checks;
  int errs;
  int pulses;

  int       m_ptr;
  int       m_len  [NUM_CH];
  logic [3:0] m_hist [NUM_CH];
  int       m_cnt;
  logic [3:0] pat;

  task automatic model_clear_states();
    for (int i = 0; i < NUM_CH; i++) begin
      m_len[i]  = 0;
      m_hist[i] = 4'b0000;
    end
    m_cnt = 0;
  endtask

  // Drives one cycle, samples the DUT mid-cycle and advances the reference model.
  task automatic applyStimulus(input logic rn, input logic c, input logic [NUM_CH-1:0] r,
                               input logic [NUM_CH-1:0] b);
    exp_t nx;
    int   g;
    int   idx;
    @(posedge clk);
    #1;
    rst_n    = rn;
    bus.clr  = c;
    bus.req  = r;
    bus.bits = b;
    @(negedge clk);
    obs_gnt = bus.gnt;
    obs_dv  = bus.det_valid;
    obs_ch  = bus.det_ch;
    obs_cnt = bus.hit_cnt;
    if (sb.size() > 0) begin
      exp_e    = sb.pop_front();
      have_exp = 1'b1;
    end else begin
      have_exp = 1'b0;
    end
    nx.valid = 1'b0;
    nx.ch    = '0;
    exp_gnt  = '0;
    if (!rn) begin
      model_clear_states();
      m_ptr = NUM_CH - 1;
    end else if (c) begin
      model_clear_states();
    end else begin
      g = -1;
      for (int i = 1; i <= NUM_CH; i++) begin
        idx = (m_ptr + i) % NUM_CH;
        if (g < 0 && r[idx]) g = idx;
      end
      if (g >= 0) begin
        exp_gnt[g] = 1'b1;
        m_ptr      = g;
        m_hist[g]  = {m_hist[g][2:0], b[g]};
        if (m_len[g] < 4) m_len[g]++;
        if (m_len[g] == 4 && m_hist[g] == pat) begin
          nx.valid = 1'b1;
          nx.ch    = CH_W'(g);
          if (m_cnt < 255) m_cnt++;
          m_len[g] = bus.overlap ? 1 : 0;
        end
      end
    end
    nx.cnt = CNT_W'(m_cnt);
    sb.push_back(nx);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(k >= 2, 1'b0, (k < 3) ? 4'b1111 : 4'b0000, 4'b0000);
      checks++;
      if (obs_gnt !== exp_gnt) begin
        errs++; $display("[TB] FAIL reset gnt: got %b want %b", obs_gnt, exp_gnt);
      end
      if (have_exp) begin
        checks++;
        if (obs_dv !== exp_e.valid || obs_cnt !== exp_e.cnt) begin
          errs++; $display("[TB] FAIL reset outputs: got v=%b cnt=%0d want v=%b cnt=%0d",
                           obs_dv, obs_cnt, exp_e.valid, exp_e.cnt);
        end
      end
      if (k == 2) begin
        checks++;
        if (obs_gnt !== 4'b0001) begin
          errs++; $display("[TB] FAIL reset first_gnt: got %b want 0001", obs_gnt);
        end
      end
    end
  endtask

  task automatic test_single_channel();
    logic [3:0] s;
    s = 4'b1101;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) applyStimulus(1'b1, 1'b0, 4'b0100, {1'b0, s[3-k], 2'b00});
      else       applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
      checks++;
      if (obs_gnt !== exp_gnt) begin
        errs++; $display("[TB] FAIL single gnt: got %b want %b", obs_gnt, exp_gnt);
      end
      if (have_exp) begin
        checks++;
        if (obs_dv !== exp_e.valid || obs_cnt !== exp_e.cnt || (exp_e.valid && obs_ch !== exp_e.ch)) begin
          errs++; $display("[TB] FAIL single det: got v=%b ch=%0d cnt=%0d want v=%b ch=%0d cnt=%0d",
                           obs_dv, obs_ch, obs_cnt, exp_e.valid, exp_e.ch, exp_e.cnt);
        end
      end
      if (obs_dv === 1'b1) pulses++;
      if (k == 4) begin
        checks++;
        if (obs_dv !== 1'b1 || obs_ch !== 2'd2 || obs_cnt !== 8'd1) begin
          errs++; $display("[TB] FAIL single pulse: got v=%b ch=%0d cnt=%0d want v=1 ch=2 cnt=1",
                           obs_dv, obs_ch, obs_cnt);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errs++; $display("[TB] FAIL single pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_overlap(input logic ov, input int want_pulses);
    logic [6:0] s;
    s = 7'b1101101;
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    bus.overlap = ov;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 7) applyStimulus(1'b1, 1'b0, 4'b0001, {3'b000, s[6-k]});
      else       applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
      checks++;
      if (obs_gnt !== exp_gnt) begin
        errs++; $display("[TB] FAIL overlap gnt: got %b want %b", obs_gnt, exp_gnt);
      end
      if (have_exp) begin
        checks++;
        if (obs_dv !== exp_e.valid || obs_cnt !== exp_e.cnt || (exp_e.valid && obs_ch !== exp_e.ch)) begin
          errs++; $display("[TB] FAIL overlap det: got v=%b ch=%0d cnt=%0d want v=%b ch=%0d cnt=%0d",
                           obs_dv, obs_ch, obs_cnt, exp_e.valid, exp_e.ch, exp_e.cnt);
        end
      end
      if (obs_dv === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== want_pulses || obs_cnt !== CNT_W'(want_pulses)) begin
      errs++; $display("[TB] FAIL overlap%0d count: got pulses=%0d cnt=%0d want %0d",
                       ov, pulses, obs_cnt, want_pulses);
    end
  endtask

  task automatic test_fairness();
    logic [NUM_CH-1:0] b;
    logic [CH_W-1:0] seen [$];
    applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000);
    pulses = 0;
    for (int k = 0; k < 18; k++) begin
      b = (k >= 8 && k < 12) ? 4'b0000 : 4'b1111;
      if (k < 16) applyStimulus(1'b1, 1'b0, 4'b1111, b);
      else        applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
      checks++;
      if (obs_gnt !== exp_gnt) begin
        errs++; $display("[TB] FAIL fair gnt: got %b want %b", obs_gnt, exp_gnt);
      end
      if (k < 8) begin
        checks++;
        if (obs_gnt !== (4'b0001 << (k % 4))) begin
          errs++; $display("[TB] FAIL fair order: cycle %0d got %b want %b", k, obs_gnt, 4'b0001 << (k % 4));
        end
      end
      if (have_exp) begin
        checks++;
        if (obs_dv !== exp_e.valid || obs_cnt !== exp_e.cnt || (exp_e.valid && obs_ch !== exp_e.ch)) begin
          errs++; $display("[TB] FAIL fair det: got v=%b ch=%0d cnt=%0d want v=%b ch=%0d cnt=%0d",
                           obs_dv, obs_ch, obs_cnt, exp_e.valid, exp_e.ch, exp_e.cnt);
        end
      end
      if (obs_dv === 1'b1) begin
        pulses++;
        seen.push_back(obs_ch);
      end
    end
    checks++;
    if (pulses !== 4) begin
      errs++; $display("[TB] FAIL back_to_back pulses: got %0d want 4", pulses);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== CH_W'(i)) begin
          errs++; $display("[TB] FAIL back_to_back ch%0d: got %0d want %0d", i, seen[i], i);
        end
      end
    end
  endtask

  task automatic test_interleave();
    logic [NUM_CH-1:0] r;
    logic [NUM_CH-1:0] b;
    logic [CH_W-1:0] seen [$];
    int at [$];
    int p1;
    int p3;
    p1 = 0;
    p3 = 0;
    for (int k = 0; k < 12; k++) begin
      r = '0;
      b = '0;
      if (p1 < 4) begin r[1] = 1'b1; b[1] = pat[3-p1]; end
      if (p3 < 4) begin r[3] = 1'b1; b[3] = pat[3-p3]; end
      applyStimulus(1'b1, 1'b0, r, b);
      checks++;
      if (obs_gnt !== exp_gnt) begin
        errs++; $display("[TB] FAIL interleave gnt: got %b want %b", obs_gnt, exp_gnt);
      end
      if (have_exp) begin
        checks++;
        if (obs_dv !== exp_e.valid || obs_cnt !== exp_e.cnt || (exp_e.valid && obs_ch !== exp_e.ch)) begin
          errs++; $display("[TB] FAIL interleave det: got v=%b ch=%0d cnt=%0d want v=%b ch=%0d cnt=%0d",
                           obs_dv, obs_ch, obs_cnt, exp_e.valid, exp_e.ch, exp_e.cnt);
        end
      end
      if (obs_dv === 1'b1) begin
        seen.push_back(obs_ch);
        at.push_back(k);
      end
      if (exp_gnt[1]) p1++;
      if (exp_gnt[3]) p3++;
    end
    checks++;
    if (seen.size() != 2) begin
      errs++; $display("[TB] FAIL interleave pulses: got %0d want 2", seen.size());
    end else if (seen[0] !== 2'd1 || seen[1] !== 2'd3 || at[1] != at[0] + 1) begin
      errs++; $display("[TB] FAIL interleave order: got ch %0d,%0d at %0d,%0d want 1,3 consecutive",
                       seen[0], seen[1], at[0], at[1]);
    end
  endtask

  task automatic test_clr();
    logic [3:0] b [6];
    logic c [6];
    b = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bus.overlap = 1'b0;
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      if (k < 5) applyStimulus(1'b1, c[k], 4'b0001, b[k]);
      else       applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
      checks++;
      if (obs_gnt !== exp_gnt) begin
        errs++; $display("[TB] FAIL clr gnt: got %b want %b", obs_gnt, exp_gnt);
      end
      if (have_exp) begin
        checks++;
        if (obs_dv !== exp_e.valid || obs_cnt !== exp_e.cnt || (exp_e.valid && obs_ch !== exp_e.ch)) begin
          errs++; $display("[TB] FAIL clr det: got v=%b ch=%0d cnt=%0d want v=%b ch=%0d cnt=%0d",
                           obs_dv, obs_ch, obs_cnt, exp_e.valid, exp_e.ch, exp_e.cnt);
        end
      end
      if (k >= 4 && obs_dv === 1'b1) pulses++;
      if (k == 4) begin
        checks++;
        if (obs_cnt !== 8'd0) begin
          errs++; $display("[TB] FAIL clr count: got %0d want 0", obs_cnt);
        end
      end
    end
    checks++;
    if (pulses !== 0) begin
      errs++; $display("[TB] FAIL clr pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_midseq_reset();
    logic [3:0] b [4];
    b = '{4'b0001, 4'b0001, 4'b0000, 4'b0001};
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) applyStimulus(k != 3, 1'b0, 4'b0001, b[k]);
      else       applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
      checks++;
      if (obs_gnt !== exp_gnt) begin
        errs++; $display("[TB] FAIL midreset gnt: got %b want %b", obs_gnt, exp_gnt);
      end
      if (have_exp) begin
        checks++;
        if (obs_dv !== exp_e.valid || obs_cnt !== exp_e.cnt) begin
          errs++; $display("[TB] FAIL midreset det: got v=%b cnt=%0d want v=%b cnt=%0d",
                           obs_dv, obs_cnt, exp_e.valid, exp_e.cnt);
        end
      end
      if (obs_dv === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errs++; $display("[TB] FAIL midreset pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_saturation();
    logic bit_v;
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    bus.overlap = 1'b1;
    pulses = 0;
    for (int k = 0; k < 802; k++) begin
      if (k == 0) bit_v = 1'b1;
      else        bit_v = (((k - 1) % 3) != 1);
      if (k < 800) applyStimulus(1'b1, 1'b0, 4'b0001, {3'b000, bit_v});
      else         applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
      checks++;
      if (obs_gnt !== exp_gnt) begin
        errs++; $display("[TB] FAIL sat gnt: got %b want %b", obs_gnt, exp_gnt);
      end
      if (have_exp) begin
        checks++;
        if (obs_dv !== exp_e.valid || obs_cnt !== exp_e.cnt || (exp_e.valid && obs_ch !== exp_e.ch)) begin
          errs++; $display("[TB] FAIL sat det: got v=%b ch=%0d cnt=%0d want v=%b ch=%0d cnt=%0d",
                           obs_dv, obs_ch, obs_cnt, exp_e.valid, exp_e.ch, exp_e.cnt);
        end
      end
      if (obs_dv === 1'b1) pulses++;
    end
    checks++;
    if (pulses < 256 || obs_cnt !== 8'hFF) begin
      errs++; $display("[TB] FAIL sat final: got pulses=%0d cnt=%h want >=256 and FF", pulses, obs_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks      = 0;
    errs        = 0;
    pat         = 4'b1101;
    rst_n       = 1'b0;
    bus.overlap = 1'b0;
    bus.clr     = 1'b0;
    bus.req     = '0;
    bus.bits    = '0;
    m_ptr       = NUM_CH - 1;
    model_clear_states();

    test_reset();
    test_single_channel();
    test_overlap(1'b1, 2);
    test_overlap(1'b0, 1);
    test_fairness();
    test_interleave();
    test_clr();
    test_midseq_reset();
    test_saturation();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
